// File: rtl/calc_port_responder.sv
// -----------------------------------------------------------------------------
// calc_port_responder
//
// Responder end of the calculator command port. A non-zero command on cmd_in
// starts a transaction: operand 1 comes with the command, operand 2 on the
// following cycle. The block then executes add / subtract / shift-left /
// shift-right and returns a one-cycle response. Only one transaction is in
// flight; commands arriving while busy are dropped silently.
//
// Parameters
//   DATA_W      operand/result width (>= 5); vectors are [0:DATA_W-1], bit 0 MSB
//   EXTRA_DELAY additional wait cycles spent in EXEC before responding (0..15)
//
// Ports
//   c_clk     in   clock, all state updates on the rising edge
//   reset_n   in   asynchronous active-low reset
//   cmd_in    in   4-bit command: 0 nop, 1 add, 2 sub, 5 shl, 6 shr, else invalid
//   data_in   in   operand 1 in the command cycle, operand 2 in the next cycle
//   out_resp  out  0 none, 1 success, 2 overflow/underflow/invalid (3 unused)
//   out_data  out  result, meaningful only while out_resp != 0
//   busy      out  high whenever a transaction is in progress
//
// Timing: command in cycle T, operand 2 in T+1, response visible in
// T+3+EXTRA_DELAY for one cycle, next command accepted from T+4+EXTRA_DELAY.
// -----------------------------------------------------------------------------
module calc_port_responder #(
  parameter int DATA_W      = 32,
  parameter int EXTRA_DELAY = 0
) (
  input  logic              c_clk,
  input  logic              reset_n,
  input  logic [3:0]        cmd_in,
  input  logic [0:DATA_W-1] data_in,
  output logic [1:0]        out_resp,
  output logic [0:DATA_W-1] out_data,
  output logic              busy
);

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  localparam logic [3:0] DELAY_CNT = 4'(EXTRA_DELAY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OP2,
    S_EXEC,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cmd_q,   cmd_d;
  logic [0:DATA_W-1]   op1_q,   op1_d;
  logic [0:DATA_W-1]   op2_q,   op2_d;
  logic [3:0]          wait_q,  wait_d;
  logic [1:0]          resp_q,  resp_d;
  logic [0:DATA_W-1]   data_q,  data_d;

  // Execution unit: purely a function of the latched command and operands.
  logic [DATA_W:0]     sum_full;
  logic [4:0]          shamt;
  logic [1:0]          res_resp;
  logic [0:DATA_W-1]   res_data;

  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    res_resp = RESP_ERR;
    res_data = '0;
    sum_full = {1'b0, op1_q} + {1'b0, op2_q};
    // Low five bits of op2; with MSB-first numbering these are the last five.
    shamt    = op2_q[DATA_W-5:DATA_W-1];

    case (cmd_q)
      CMD_ADD: begin
        if (!sum_full[DATA_W]) begin
          res_resp = RESP_OK;
          res_data = sum_full[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        // op1 == op2 falls into the success branch and yields zero.
        if (op2_q <= op1_q) begin
          res_resp = RESP_OK;
          res_data = op1_q - op2_q;
        end
      end
      CMD_SHL: begin
        res_resp = RESP_OK;
        res_data = op1_q << shamt;
      end
      CMD_SHR: begin
        res_resp = RESP_OK;
        res_data = op1_q >> shamt;
      end
      default: begin
        // Invalid commands (and nop, which is never latched) report an error.
        res_resp = RESP_ERR;
        res_data = '0;
      end
    endcase
  end

  // Next-state and output-register logic. The response registers default to
  // zero every cycle, so they hold a value only during the single RESP cycle.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    wait_d  = wait_q;
    resp_d  = RESP_NONE;
    data_d  = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_in != CMD_NOP) begin
          cmd_d   = cmd_in;
          op1_d   = data_in;
          state_d = S_OP2;
        end
      end
      S_OP2: begin
        // cmd_in is deliberately not looked at here.
        op2_d   = data_in;
        wait_d  = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (wait_q == DELAY_CNT) begin
          resp_d  = res_resp;
          data_d  = res_data;
          wait_d  = '0;
          state_d = S_RESP;
        end else begin
          wait_d  = wait_q + 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      wait_q  <= '0;
      resp_q  <= RESP_NONE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      wait_q  <= wait_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
    end
  end

  assign out_resp = resp_q;
  assign out_data = data_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_calc_port_responder.sv
// -----------------------------------------------------------------------------
// tb_calc_port_responder
//
// Scoreboard bench for calc_port_responder. Each transaction pushes its
// expected response (code, data, cycle of appearance) when it is driven; a
// monitor on the falling clock edge pops and compares whenever the DUT
// responds. A second instance with EXTRA_DELAY=4 covers the delayed response.
// -----------------------------------------------------------------------------
module tb_calc_port_responder;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        c_clk;
  logic        reset_n;
  logic [3:0]  cmd_in;
  logic [0:31] data_in;
  logic [1:0]  out_resp;
  logic [0:31] out_data;
  logic        busy;

  logic [3:0]  cmd4;
  logic [0:31] data4;
  logic [1:0]  resp4;
  logic [0:31] odata4;
  logic        busy4;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;

  calc_port_responder #(.DATA_W(32), .EXTRA_DELAY(0)) dut (
    .c_clk   (c_clk),
    .reset_n (reset_n),
    .cmd_in  (cmd_in),
    .data_in (data_in),
    .out_resp(out_resp),
    .out_data(out_data),
    .busy    (busy)
  );

  calc_port_responder #(.DATA_W(32), .EXTRA_DELAY(4)) dut_d4 (
    .c_clk   (c_clk),
    .reset_n (reset_n),
    .cmd_in  (cmd4),
    .data_in (data4),
    .out_resp(resp4),
    .out_data(odata4),
    .busy    (busy4)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  always @(posedge c_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference behaviour written straight from the command definitions.
  function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (c)
      4'd1:    model = s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]};
      4'd2:    model = (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
      4'd5:    model = {2'd1, a << b[4:0]};
      4'd6:    model = {2'd1, a >> b[4:0]};
      default: model = {2'd2, 32'd0};
    endcase
  endfunction

  // Monitor for the main instance.
  always @(negedge c_clk) begin
    if (out_resp != 2'd0) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", out_resp, 2'd0);
      end else begin
        mon_e = sb.pop_front();
        check("resp", out_resp, mon_e.resp);
        check("data", out_data, mon_e.data);
        check("latency", cyc, mon_e.cyc);
      end
    end
  end

  // One transaction: command in T, op2 in T+1, returns after the T+3 check so
  // the next call drives its command in T+4 (earliest acceptance). With
  // reassert set, cmd 1 is held high through T+1..T+3 and must be ignored.
  task automatic do_txn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic reassert);
    exp_t e;
    logic [33:0] m;
    int t0;
    @(posedge c_clk); #1;
    cmd_in  = c;
    data_in = a;
    t0      = cyc;
    m       = model(c, a, b);
    e.resp  = m[33:32];
    e.data  = m[31:0];
    e.cyc   = t0 + 3;
    sb.push_back(e);
    @(negedge c_clk); check("busy_T0", busy, 1'b0);
    @(posedge c_clk); #1;
    cmd_in  = reassert ? 4'd1 : 4'd0;
    data_in = b;
    @(negedge c_clk); check("busy_T1", busy, 1'b1);
    @(posedge c_clk); #1;
    data_in = reassert ? 32'hDEAD_BEEF : 32'd0;
    @(negedge c_clk); check("busy_T2", busy, 1'b1);
    @(posedge c_clk); #1;
    @(negedge c_clk); check("busy_T3", busy, 1'b1);
  endtask

  task automatic idle(input int n);
    @(posedge c_clk); #1;
    cmd_in  = 4'd0;
    data_in = '0;
    repeat (n) @(posedge c_clk);
    #1;
  endtask

  initial begin
    logic [3:0] ops [4] = '{4'd1, 4'd2, 4'd5, 4'd6};
    int t0;
    cmd_in  = 4'd0;
    data_in = '0;
    cmd4    = 4'd0;
    data4   = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("rst_resp", out_resp, 2'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_resp_d4", resp4, 2'd0);
    check("rst_busy_d4", busy4, 1'b0);
    repeat (3) @(posedge c_clk);
    @(negedge c_clk) reset_n = 1'b1;

    // Walking-bit add.
    for (int k = 0; k <= 30; k++) do_txn(4'd1, 32'd1 << k, 32'd0, 1'b0);

    // Overflow boundaries.
    do_txn(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    do_txn(4'd1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);

    // Subtract and underflow.
    do_txn(4'd2, 32'd10, 32'd3, 1'b0);
    do_txn(4'd2, 32'd3, 32'd3, 1'b0);
    do_txn(4'd2, 32'd3, 32'd10, 1'b0);

    // Shifts.
    do_txn(4'd5, 32'h0000_0001, 32'd31, 1'b0);
    do_txn(4'd6, 32'h8000_0000, 32'd35, 1'b0);
    do_txn(4'd5, 32'h1234_5678, 32'd0, 1'b0);
    do_txn(4'd6, 32'hCAFE_F00D, 32'd32, 1'b0);

    // Commands while busy are ignored; invalid commands report an error.
    do_txn(4'd1, 32'd5, 32'd6, 1'b1);
    do_txn(4'd9, 32'd7, 32'd8, 1'b0);
    do_txn(4'd3, 32'd1, 32'd1, 1'b0);
    do_txn(4'd15, 32'd2, 32'd2, 1'b0);

    // Mixed random operations.
    for (int i = 0; i < 16; i++)
      do_txn(ops[$urandom_range(0, 3)], $urandom, $urandom, 1'b0);
    idle(2);

    // Reset in the middle of a transaction: no response may ever follow.
    @(posedge c_clk); #1;
    cmd_in  = 4'd1;
    data_in = 32'd100;
    @(posedge c_clk); #1;
    cmd_in  = 4'd0;
    data_in = 32'd200;
    @(posedge c_clk); #1;
    data_in = '0;
    reset_n = 1'b0;
    #1;
    check("midrst_resp", out_resp, 2'd0);
    check("midrst_data", out_data, 32'd0);
    check("midrst_busy", busy, 1'b0);
    @(negedge c_clk) reset_n = 1'b1;
    idle(6);
    do_txn(4'd1, 32'd40, 32'd2, 1'b0);
    idle(2);

    // Delayed instance: add 2+2 answers at T+7 for exactly one cycle.
    @(posedge c_clk); #1;
    cmd4  = 4'd1;
    data4 = 32'd2;
    t0    = cyc;
    @(posedge c_clk); #1;
    cmd4  = 4'd0;
    data4 = 32'd2;
    @(posedge c_clk); #1;
    data4 = '0;
    repeat (7) begin
      @(negedge c_clk);
      check("d4_resp", resp4, (cyc - t0 == 7) ? 2'd1 : 2'd0);
      check("d4_data", odata4, (cyc - t0 == 7) ? 32'd4 : 32'd0);
      check("d4_busy", busy4, (cyc - t0 <= 7) ? 1'b1 : 1'b0);
    end

    idle(4);
    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_port_responder.md
Name: calc_port_responder

Overview:
- Responder end of the calculator command port: accepts a command plus two operands over the `cmd_in`/`data_in` interface the addition benches drive.
- Executes add, subtract, shift-left or shift-right and returns a response code plus result on `out_resp`/`out_data`.
- Sits between the port stimulus (bench or upstream master) and the result checker; one transaction in flight at a time.

Parameters:
- DATA_W, 32, operand/result width; vectors are [0:DATA_W-1], bit 0 is MSB.
- EXTRA_DELAY, 0, additional wait cycles in EXEC before the response (0..15).

Ports:
- c_clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cmd_in  input  4  command: 0 nop, 1 add, 2 sub, 5 shl, 6 shr; others invalid.
- data_in  input  DATA_W  operand1 in the command cycle, operand2 in the following cycle.
- out_resp  output  2  0 no response, 1 success, 2 overflow/underflow/invalid command; 3 never driven.
- out_data  output  DATA_W  result; valid only when out_resp != 0.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - out_resp=0, out_data=0, busy=0.
  - Wait counter and latched cmd/op1/op2 cleared.
  - Reset asserted mid-transaction aborts it; no response is ever issued for it.
- Four-state FSM:
  - IDLE -> OP2 when cmd_in != 0. Latch cmd=cmd_in, op1=data_in.
  - IDLE stays in IDLE when cmd_in == 0.
  - OP2 -> EXEC unconditionally. Latch op2=data_in; cmd_in is ignored in this cycle.
  - EXEC computes and registers the result. It holds for EXTRA_DELAY cycles using the wait counter, then -> RESP.
  - RESP drives out_resp/out_data for exactly one cycle, then -> IDLE. out_resp/out_data return to 0 on the next edge.
- Latency: cmd cycle T, op2 cycle T+1. Response is visible at T+3+EXTRA_DELAY, for one cycle. Earliest next accepted command is T+4+EXTRA_DELAY.
- cmd_in != 0 while busy=1 is ignored: no latch, no error response.
- Arithmetic, all unsigned DATA_W:
  - add: carry out -> resp 2, data 0; else resp 1, data = op1+op2 (truncated).
  - sub: op2 > op1 -> resp 2, data 0; op1 == op2 -> resp 1, data 0; else resp 1, data = op1-op2.
  - shl: data = op1 << op2[DATA_W-5:DATA_W-1] (low 5 bits, 0..31); zero fill; resp 1.
  - shr: data = op1 >> low 5 bits of op2, logical; resp 1.
  - Shift amount 0 returns op1 unchanged.
  - Invalid cmd (3,4,7..15): full transaction timing is still consumed (op2 cycle included); resp 2, data 0.
- Boundary cases:
  - 0xFFFFFFFF+1: overflow (resp 2).
  - 0x7FFFFFFF+0x80000000 = 0xFFFFFFFF: resp 1.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Walking-bit add: for x = 1<<k, k=0..30, cmd 1, op1=x, op2=0 -> resp 1, data=x at T+3; busy high T+1..T+3.
- Overflow: add 0xFFFFFFFF + 0x00000001 -> resp 2, data 0. Then add 0x7FFFFFFF + 0x80000000 -> resp 1, data 0xFFFFFFFF.
- Subtract and underflow:
  - sub 10-3 -> resp 1, data 7.
  - sub 3-3 -> resp 1, data 0.
  - sub 3-10 -> resp 2, data 0.
- Shifts:
  - shl 0x00000001 by 31 -> 0x80000000.
  - shr 0x80000000 by 35 (low 5 bits=3) -> 0x10000000.
  - shl by 0 -> op1.
  - All resp 1.
- Busy and invalid handling:
  - cmd 1 reasserted in cycles T+1..T+3 -> exactly one response, for the first transaction.
  - cmd 9 -> resp 2, data 0 at T+3.
- Reset and delay:
  - reset_n pulsed low at T+2 -> outputs 0 immediately; no response follows; new cmd accepted after release.
  - With EXTRA_DELAY=4, add 2+2 -> resp 1, data 4 at T+7.
